// File: rtl/ysyx_22050612_idu_stage.sv
// Decode stage: decodes one RV32/RV64 instruction per cycle into a two-entry skid buffer.
// Latency 1 cycle; in_ready comes only from registered state, flush and rst, so out_ready has no path to it.
module ysyx_22050612_idu_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [5:0]      out_shamt,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic            out_ebreak,
    output logic            out_illegal
);
    localparam bit RV64 = (XLEN == 64);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [5:0]      shamt;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic            ebreak;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state;
    entry_t m_ent, k_ent, dec;
    logic [63:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sel;
    logic [2:0]  fmt;
    logic        ill;
    logic        acc, cons;

    // Immediates are formed at 64 bits and truncated, so XLEN=32 needs no special casing.
    assign imm_i = {{52{in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{52{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_j = {{44{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    assign imm_u = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};

    always_comb begin
        fmt = FMT_R;
        ill = 1'b0;
        case (in_inst[6:0])
            7'b0110111, 7'b0010111:                       fmt = FMT_U;
            7'b1101111:                                   fmt = FMT_J;
            7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: fmt = FMT_I;
            7'b0011011: begin
                fmt = FMT_I;
                ill = !RV64;
            end
            7'b1100011:                                   fmt = FMT_B;
            7'b0100011:                                   fmt = FMT_S;
            7'b0110011:                                   fmt = FMT_R;
            7'b0111011:                                   ill = !RV64;
            default:                                      ill = 1'b1;
        endcase
        // RV32 shifts only have a 5-bit shamt; bit 25 set is reserved.
        if (!RV64 && in_inst[6:0] == 7'b0010011 && in_inst[13:12] == 2'b01 && in_inst[25])
            ill = 1'b1;
        if (ill)
            fmt = FMT_R;

        case (fmt)
            FMT_I:   imm_sel = imm_i;
            FMT_S:   imm_sel = imm_s;
            FMT_B:   imm_sel = imm_b;
            FMT_U:   imm_sel = imm_u;
            FMT_J:   imm_sel = imm_j;
            default: imm_sel = 64'd0;
        endcase

        dec.pc      = in_pc;
        dec.imm     = imm_sel[XLEN-1:0];
        dec.fmt     = fmt;
        dec.rd      = in_inst[11:7];
        dec.rs1     = in_inst[19:15];
        dec.rs2     = in_inst[24:20];
        dec.shamt   = {RV64 ? in_inst[25] : 1'b0, in_inst[24:20]};
        dec.opcode  = in_inst[6:0];
        dec.funct3  = in_inst[14:12];
        dec.funct7  = in_inst[31:25];
        dec.ebreak  = (in_inst == 32'h00100073);
        dec.illegal = ill;
    end

    assign in_ready  = !rst && !flush && (state != FULL);
    assign out_valid = (state != EMPTY);
    assign acc       = in_valid && in_ready;
    assign cons      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            m_ent <= '0;
            k_ent <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: if (acc) begin
                    m_ent <= dec;
                    state <= ONE;
                end
                ONE: begin
                    if (acc && cons) begin
                        m_ent <= dec;
                    end else if (acc) begin
                        k_ent <= dec;
                        state <= FULL;
                    end else if (cons) begin
                        state <= EMPTY;
                    end
                end
                FULL: if (cons) begin
                    m_ent <= k_ent;
                    state <= ONE;
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign out_pc      = m_ent.pc;
    assign out_imm     = m_ent.imm;
    assign out_fmt     = m_ent.fmt;
    assign out_rd      = m_ent.rd;
    assign out_rs1     = m_ent.rs1;
    assign out_rs2     = m_ent.rs2;
    assign out_shamt   = m_ent.shamt;
    assign out_opcode  = m_ent.opcode;
    assign out_funct3  = m_ent.funct3;
    assign out_funct7  = m_ent.funct7;
    assign out_ebreak  = m_ent.ebreak;
    assign out_illegal = m_ent.illegal;

endmodule

// File: tb/tb_ysyx_22050612_idu_stage.sv
// Bench for the decode stage: one XLEN=64 and one XLEN=32 instance share all inputs,
// checked against a queue-based reference of accepted instructions.
module tb_ysyx_22050612_idu_stage;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;

    logic        a_in_ready, a_out_valid, a_out_ebreak, a_out_illegal;
    logic [63:0] a_out_pc, a_out_imm;
    logic [2:0]  a_out_fmt, a_out_funct3;
    logic [4:0]  a_out_rd, a_out_rs1, a_out_rs2;
    logic [5:0]  a_out_shamt;
    logic [6:0]  a_out_opcode, a_out_funct7;

    logic        b_in_ready, b_out_valid, b_out_ebreak, b_out_illegal;
    logic [31:0] b_out_pc, b_out_imm;
    logic [2:0]  b_out_fmt, b_out_funct3;
    logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2;
    logic [5:0]  b_out_shamt;
    logic [6:0]  b_out_opcode, b_out_funct7;

    ysyx_22050612_idu_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_out_pc), .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_rd(a_out_rd),
        .out_rs1(a_out_rs1), .out_rs2(a_out_rs2), .out_shamt(a_out_shamt),
        .out_opcode(a_out_opcode), .out_funct3(a_out_funct3), .out_funct7(a_out_funct7),
        .out_ebreak(a_out_ebreak), .out_illegal(a_out_illegal)
    );

    ysyx_22050612_idu_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_out_pc), .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_rd(b_out_rd),
        .out_rs1(b_out_rs1), .out_rs2(b_out_rs2), .out_shamt(b_out_shamt),
        .out_opcode(b_out_opcode), .out_funct3(b_out_funct3), .out_funct7(b_out_funct7),
        .out_ebreak(b_out_ebreak), .out_illegal(b_out_illegal)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q_inst[$];
    logic [63:0] q_pc[$];
    logic [63:0] drained[$];
    bit          last_acc;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic [14:0] regs;
        logic [5:0]  shamt;
        bit          ill64;
        bit          ill32;
        bit          ebreak;
    } vec_t;
    vec_t tv[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference decode built from the field layouts with signed arithmetic.
    function automatic void ref_dec(input logic [31:0] inst, input bit rv64,
                                    output logic [2:0] fmt, output logic [63:0] imm, output bit ill);
        longint si, t;
        si  = $signed(inst);
        t   = 0;
        ill = 1'b0;
        fmt = 3'd0;
        case (inst[6:0])
            7'h37, 7'h17:               fmt = 3'd4;
            7'h6f:                      fmt = 3'd5;
            7'h67, 7'h03, 7'h13, 7'h73: fmt = 3'd1;
            7'h1b: begin fmt = 3'd1; ill = !rv64; end
            7'h63:                      fmt = 3'd3;
            7'h23:                      fmt = 3'd2;
            7'h33:                      fmt = 3'd0;
            7'h3b:                      ill = !rv64;
            default:                    ill = 1'b1;
        endcase
        if (!rv64 && inst[6:0] == 7'h13 && (inst[14:12] == 3'b001 || inst[14:12] == 3'b101) && inst[25])
            ill = 1'b1;
        if (ill) fmt = 3'd0;
        case (fmt)
            3'd1: t = si >>> 20;
            3'd2: begin t = si >>> 25; t = t * 32 + longint'(inst[11:7]); end
            3'd3: begin
                t = si >>> 31;
                t = t * 4096 + longint'(inst[7]) * 2048 + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
            end
            3'd4: begin t = si >>> 12; t = t * 4096; end
            3'd5: begin
                t = si >>> 31;
                t = t * 1048576 + longint'(inst[19:12]) * 4096 + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
            end
            default: t = 0;
        endcase
        imm = rv64 ? 64'(t) : {32'b0, 32'(t)};
    endfunction

    task automatic verify();
        logic [31:0] inst;
        logic [2:0]  f, f32;
        logic [63:0] im, im32;
        bit          il, il32;
        check("in_ready", a_in_ready, q_inst.size() < 2);
        check("in_ready32", b_in_ready, q_inst.size() < 2);
        check("out_valid", a_out_valid, q_inst.size() > 0);
        check("out_valid32", b_out_valid, q_inst.size() > 0);
        if (q_inst.size() > 0) begin
            inst = q_inst[0];
            ref_dec(inst, 1'b1, f, im, il);
            ref_dec(inst, 1'b0, f32, im32, il32);
            check("pc", a_out_pc, q_pc[0]);
            check("pc32", b_out_pc, q_pc[0][31:0]);
            check("fmt", a_out_fmt, f);
            check("imm", a_out_imm, im);
            check("illegal", a_out_illegal, il);
            check("fmt32", b_out_fmt, f32);
            check("imm32", b_out_imm, im32);
            check("illegal32", b_out_illegal, il32);
            check("fields", {a_out_rd, a_out_rs1, a_out_rs2, a_out_opcode, a_out_funct3, a_out_funct7},
                  {inst[11:7], inst[19:15], inst[24:20], inst[6:0], inst[14:12], inst[31:25]});
            check("fields32", {b_out_rd, b_out_rs1, b_out_rs2, b_out_opcode, b_out_funct3, b_out_funct7},
                  {inst[11:7], inst[19:15], inst[24:20], inst[6:0], inst[14:12], inst[31:25]});
            check("shamt", a_out_shamt, inst[25:20]);
            check("shamt32", b_out_shamt, {1'b0, inst[24:20]});
            check("ebreak", {a_out_ebreak, b_out_ebreak}, {2{inst == 32'h00100073}});
        end
    endtask

    // Drives one cycle of inputs from just after a negedge, updates the model, verifies next cycle.
    task automatic cycle(input bit v, input logic [31:0] inst, input logic [63:0] pc,
                         input bit ordy, input bit fl);
        bit acc, cons;
        in_valid  = v;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        acc  = v && !fl && q_inst.size() < 2;
        cons = ordy && q_inst.size() > 0;
        if (cons) begin
            drained.push_back(a_out_pc);
            void'(q_inst.pop_front());
            void'(q_pc.pop_front());
        end
        if (fl) begin
            q_inst.delete();
            q_pc.delete();
        end else if (acc) begin
            q_inst.push_back(inst);
            q_pc.push_back(pc);
        end
        last_acc = acc;
        @(posedge clk);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        verify();
    endtask

    function automatic logic [31:0] gen_inst();
        logic [6:0]  ops[12] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h13,
                                 7'h73, 7'h1b, 7'h63, 7'h23, 7'h33, 7'h3b};
        logic [31:0] r;
        int          sel;
        r   = $urandom;
        sel = $urandom_range(0, 13);
        if (sel < 12) return {r[31:7], ops[sel]};
        if (sel == 12) return r;
        return 32'h00100073;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] bi[4];
        logic [63:0] bp[4];
        logic [63:0] pc;
        int          idx;

        tv[0]  = '{32'hfff10093, 3'd1, 64'hffffffffffffffff, {5'd1, 5'd2, 5'd31},  6'd63, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{32'hfe000ee3, 3'd3, 64'hfffffffffffffffc, {5'd29, 5'd0, 5'd0},  6'd32, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{32'h00113423, 3'd2, 64'd8,                {5'd8, 5'd2, 5'd1},   6'd1,  1'b0, 1'b0, 1'b0};
        tv[3]  = '{32'h0040006f, 3'd5, 64'd4,                {5'd0, 5'd0, 5'd4},   6'd4,  1'b0, 1'b0, 1'b0};
        tv[4]  = '{32'h00100073, 3'd1, 64'd1,                {5'd0, 5'd0, 5'd1},   6'd1,  1'b0, 1'b0, 1'b1};
        tv[5]  = '{32'h0000000b, 3'd0, 64'd0,                {5'd0, 5'd0, 5'd0},   6'd0,  1'b1, 1'b1, 1'b0};
        tv[6]  = '{32'h0010009b, 3'd1, 64'd1,                {5'd1, 5'd0, 5'd1},   6'd1,  1'b0, 1'b1, 1'b0};
        tv[7]  = '{32'h800002b7, 3'd4, 64'hffffffff80000000, {5'd5, 5'd0, 5'd0},   6'd0,  1'b0, 1'b0, 1'b0};
        tv[8]  = '{32'h02009093, 3'd1, 64'd32,               {5'd1, 5'd1, 5'd0},   6'd32, 1'b0, 1'b1, 1'b0};
        tv[9]  = '{32'h00b50533, 3'd0, 64'd0,                {5'd10, 5'd10, 5'd11}, 6'd11, 1'b0, 1'b0, 1'b0};
        tv[10] = '{32'h0000003b, 3'd0, 64'd0,                {5'd0, 5'd0, 5'd0},   6'd0,  1'b0, 1'b1, 1'b0};
        tv[11] = '{32'h00000010, 3'd0, 64'd0,                {5'd0, 5'd0, 5'd0},   6'd0,  1'b1, 1'b1, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 32'd0; in_pc = 64'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_in_ready", a_in_ready, 1'b0);
        check("rst_out_valid", {a_out_valid, b_out_valid}, 2'b00);
        check("rst_pc_imm", {a_out_pc, a_out_imm} == 128'd0, 1'b1);
        check("rst_fields", {a_out_fmt, a_out_rd, a_out_rs1, a_out_rs2, a_out_shamt, a_out_opcode,
                             a_out_funct3, a_out_funct7, a_out_ebreak, a_out_illegal}, 64'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", a_in_ready, 1'b1);

        // Directed decode vectors, one per cycle at full throughput.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, tv[i].inst, 64'h8000_0000 + 64'(i * 4), 1'b1, 1'b0);
            check($sformatf("vec%0d_valid", i), a_out_valid, 1'b1);
            check($sformatf("vec%0d_fmt", i), a_out_fmt, tv[i].fmt);
            check($sformatf("vec%0d_imm", i), a_out_imm, tv[i].imm);
            check($sformatf("vec%0d_regs", i), {a_out_rd, a_out_rs1, a_out_rs2}, tv[i].regs);
            check($sformatf("vec%0d_shamt", i), a_out_shamt, tv[i].shamt);
            check($sformatf("vec%0d_ill", i), a_out_illegal, tv[i].ill64);
            check($sformatf("vec%0d_ebreak", i), a_out_ebreak, tv[i].ebreak);
            check($sformatf("vec%0d_ill32", i), b_out_illegal, tv[i].ill32);
            check($sformatf("vec%0d_imm32", i), b_out_imm, tv[i].ill32 ? 64'd0 : {32'd0, tv[i].imm[31:0]});
            check($sformatf("vec%0d_shamt32", i), b_out_shamt, {1'b0, tv[i].shamt[4:0]});
        end
        cycle(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);

        // Backpressure: four offered with out_ready low, only two land.
        for (int i = 0; i < 4; i++) begin
            bi[i] = tv[i].inst;
            bp[i] = 64'h100 + 64'(i * 4);
        end
        drained.delete();
        cycle(1'b1, bi[0], bp[0], 1'b0, 1'b0);
        cycle(1'b1, bi[1], bp[1], 1'b0, 1'b0);
        check("bp_in_ready_full", a_in_ready, 1'b0);
        check("bp_head", a_out_pc, bp[0]);
        cycle(1'b1, bi[2], bp[2], 1'b0, 1'b0);
        cycle(1'b1, bi[3], bp[3], 1'b0, 1'b0);
        check("bp_in_ready_held", a_in_ready, 1'b0);
        check("bp_head_stable", a_out_pc, bp[0]);
        idx = 2;
        for (int n = 0; n < 12 && (idx < 4 || q_inst.size() > 0); n++) begin
            cycle(idx < 4, bi[idx < 4 ? idx : 0], bp[idx < 4 ? idx : 0], 1'b1, 1'b0);
            if (last_acc) idx++;
        end
        check("bp_drain_count", drained.size(), 4);
        for (int k = 0; k < 4 && k < drained.size(); k++)
            check($sformatf("bp_order%0d", k), drained[k], bp[k]);

        // Flush from FULL discards both entries.
        cycle(1'b1, bi[0], 64'h200, 1'b0, 1'b0);
        cycle(1'b1, bi[1], 64'h204, 1'b0, 1'b0);
        cycle(1'b0, 32'd0, 64'd0, 1'b0, 1'b1);
        check("flush_valid", a_out_valid, 1'b0);
        cycle(1'b1, bi[2], 64'h300, 1'b0, 1'b0);
        check("flush_next_valid", a_out_valid, 1'b1);
        check("flush_next_pc", a_out_pc, 64'h300);
        drained.delete();
        cycle(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        cycle(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        check("flush_drain_count", drained.size(), 1);
        if (drained.size() > 0) check("flush_drain_pc", drained[0], 64'h300);

        // Random traffic against the queue model.
        pc = 64'h8000_1000;
        repeat (3000) begin
            cycle($urandom_range(0, 3) != 0, gen_inst(), pc, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 31) == 0);
            pc += 64'd4;
        end

        // Reset while FULL clears everything.
        cycle(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        cycle(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        cycle(1'b1, bi[0], 64'h400, 1'b0, 1'b0);
        cycle(1'b1, bi[1], 64'h404, 1'b0, 1'b0);
        check("pre_rst_full", a_in_ready, 1'b0);
        rst = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        q_inst.delete();
        q_pc.delete();
        check("rst_full_valid", {a_out_valid, b_out_valid}, 2'b00);
        check("rst_full_in_ready", a_in_ready, 1'b0);
        check("rst_full_pc_imm", {a_out_pc, a_out_imm} == 128'd0, 1'b1);
        check("rst_full_fields", {a_out_fmt, a_out_rd, a_out_rs1, a_out_rs2, a_out_shamt, a_out_opcode,
                                  a_out_funct3, a_out_funct7, a_out_ebreak, a_out_illegal}, 64'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_release_in_ready", a_in_ready, 1'b1);
        cycle(1'b1, bi[3], 64'h500, 1'b1, 1'b0);
        check("post_rst_pc", a_out_pc, 64'h500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
